// File: rtl/jzjpcc_rd_write_pkg.sv
// Shared types for the register-file write-port arbiter between writeback and the MDU.
package jzjpcc_rd_write_pkg;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } rd_write_t;

  localparam logic [4:0] X0_ADDR = 5'd0;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } stall_state_e;

endpackage

// File: rtl/jzjpcc_rd_write_fifo.sv
// Synchronous FIFO of pending MDU register writes; exposes per-entry valid/addr for hazard masking.
module jzjpcc_rd_write_fifo
  import jzjpcc_rd_write_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  rd_write_t                 wdata_i,
  output rd_write_t                 head_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [DEPTH-1:0]          entry_vld_o,
  output logic [DEPTH-1:0][4:0]     entry_addr_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] off;
  rd_write_t     mem_q [DEPTH];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    count_d  = count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off             = PW'(i) - rd_ptr_q;
      entry_vld_o[i]  = ({1'b0, off} < count_q);
      entry_addr_o[i] = mem_q[i].addr;
    end
  end

endmodule

// File: rtl/jzjpcc_rd_write_arbiter.sv
// Register-file write-port arbiter: writeback has priority, MDU results queue and drain into idle
// cycles, and a starvation counter forces a one-cycle pipeline stall to drain the queue head.
module jzjpcc_rd_write_arbiter
  import jzjpcc_rd_write_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [4:0]                      wb_rdAddr,
  input  logic [31:0]                     wb_rd,
  input  logic                            wb_rdWriteEnable,
  input  logic                            mdu_valid,
  output logic                            mdu_ready,
  input  logic [4:0]                      mdu_rdAddr,
  input  logic [31:0]                     mdu_rd,
  output logic [4:0]                      rf_rdAddr,
  output logic [31:0]                     rf_rd,
  output logic                            rf_rdWriteEnable,
  output logic                            pipelineStall,
  output logic [31:0]                     pendingMask,
  output logic [$clog2(FIFO_DEPTH):0]     fifoCount
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  stall_state_e                state_q, state_d;
  logic [SW-1:0]               starve_q, starve_d;
  logic                        wb_write;
  logic                        fifo_empty;
  logic                        push;
  logic                        pop;
  rd_write_t                   mdu_entry;
  rd_write_t                   head;
  logic [FIFO_DEPTH-1:0]       entry_vld;
  logic [FIFO_DEPTH-1:0][4:0]  entry_addr;

  assign mdu_entry     = '{addr: mdu_rdAddr, data: mdu_rd};
  assign fifo_empty    = (fifoCount == '0);
  // Readiness comes from registered occupancy only, so a same-cycle pop never frees a slot.
  assign mdu_ready     = (fifoCount < CW'(FIFO_DEPTH));
  assign push          = mdu_valid && mdu_ready && (mdu_rdAddr != X0_ADDR);
  assign pipelineStall = (state_q == DRAIN);
  assign wb_write      = wb_rdWriteEnable && (wb_rdAddr != X0_ADDR) && !pipelineStall;

  jzjpcc_rd_write_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (push),
    .pop_i        (pop),
    .wdata_i      (mdu_entry),
    .head_o       (head),
    .count_o      (fifoCount),
    .entry_vld_o  (entry_vld),
    .entry_addr_o (entry_addr)
  );

  always_comb begin
    rf_rdWriteEnable = 1'b0;
    rf_rdAddr        = wb_rdAddr;
    rf_rd            = wb_rd;
    pop              = 1'b0;
    if (wb_write) begin
      rf_rdWriteEnable = 1'b1;
    end else if (!fifo_empty) begin
      rf_rdWriteEnable = 1'b1;
      rf_rdAddr        = head.addr;
      rf_rd            = head.data;
      pop              = 1'b1;
    end
  end

  // DRAIN is entered on the edge the counter saturates, so the stall lands on the next cycle.
  always_comb begin
    starve_d = starve_q;
    state_d  = state_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (starve_q < SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
    case (state_q)
      RUN:     if (starve_d == SW'(STARVE_LIMIT)) state_d = DRAIN;
      DRAIN:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= RUN;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    pendingMask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_vld[i]) pendingMask[entry_addr[i]] = 1'b1;
    end
    pendingMask[0] = 1'b0;
  end

endmodule

// File: tb/tb_jzjpcc_rd_write_arbiter.sv
// Directed and randomized bench for the register-file write-port arbiter, checked against a queue model.
module tb_jzjpcc_rd_write_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  wb_rdAddr;
  logic [31:0] wb_rd;
  logic        wb_rdWriteEnable;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rdAddr;
  logic [31:0] mdu_rd;
  logic [4:0]  rf_rdAddr;
  logic [31:0] rf_rd;
  logic        rf_rdWriteEnable;
  logic        pipelineStall;
  logic [31:0] pendingMask;
  logic [1:0]  fifoCount;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   starve  = 0;
  bit   stall_m = 1'b0;
  int   ung;

  jzjpcc_rd_write_arbiter #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .wb_rdAddr        (wb_rdAddr),
    .wb_rd            (wb_rd),
    .wb_rdWriteEnable (wb_rdWriteEnable),
    .mdu_valid        (mdu_valid),
    .mdu_ready        (mdu_ready),
    .mdu_rdAddr       (mdu_rdAddr),
    .mdu_rd           (mdu_rd),
    .rf_rdAddr        (rf_rdAddr),
    .rf_rd            (rf_rd),
    .rf_rdWriteEnable (rf_rdWriteEnable),
    .pipelineStall    (pipelineStall),
    .pendingMask      (pendingMask),
    .fifoCount        (fifoCount)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_wbw();
    return wb_rdWriteEnable && (wb_rdAddr != 5'd0) && !stall_m;
  endfunction

  // Compare every output against the model in the middle of the cycle.
  task automatic settle();
    logic [31:0] mask;
    @(negedge clock);
    mask = 32'd0;
    foreach (q[i]) mask[q[i].a] = 1'b1;
    mask[0] = 1'b0;
    chk("m_ready", mdu_ready, (q.size() < DEPTH));
    chk("m_stall", pipelineStall, stall_m);
    chk("m_mask", pendingMask, mask);
    chk("m_count", fifoCount, q.size());
    if (model_wbw()) begin
      chk("m_we", rf_rdWriteEnable, 1);
      chk("m_addr", rf_rdAddr, wb_rdAddr);
      chk("m_data", rf_rd, wb_rd);
    end else if (q.size() > 0) begin
      chk("m_we", rf_rdWriteEnable, 1);
      chk("m_addr", rf_rdAddr, q[0].a);
      chk("m_data", rf_rd, q[0].d);
    end else begin
      chk("m_we", rf_rdWriteEnable, 0);
    end
  endtask

  // Apply the clock edge to the model, then leave the bench 1 time unit after the edge.
  task automatic advance();
    bit pop_m, push_m;
    @(posedge clock);
    if (!reset) begin
      q.delete();
      starve  = 0;
      stall_m = 1'b0;
    end else begin
      pop_m  = !model_wbw() && (q.size() > 0);
      push_m = mdu_valid && (q.size() < DEPTH) && (mdu_rdAddr != 5'd0);
      if (q.size() == 0 || pop_m) starve = 0;
      else if (starve < LIMIT) starve++;
      stall_m = !stall_m && (starve == LIMIT);
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back('{a: mdu_rdAddr, d: mdu_rd});
    end
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic wb(input bit en, input logic [4:0] a, input logic [31:0] d);
    wb_rdWriteEnable = en;
    wb_rdAddr        = a;
    wb_rd            = d;
  endtask

  task automatic mdu(input bit v, input logic [4:0] a, input logic [31:0] d);
    mdu_valid  = v;
    mdu_rdAddr = a;
    mdu_rd     = d;
  endtask

  initial begin
    reset = 1'b0;
    wb(0, 5'd0, 32'd0);
    mdu(0, 5'd0, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    step();
    reset = 1'b1;

    // Reset state
    settle();
    chk("rst_ready", mdu_ready, 1);
    chk("rst_stall", pipelineStall, 0);
    chk("rst_mask", pendingMask, 0);
    chk("rst_count", fifoCount, 0);
    chk("rst_we", rf_rdWriteEnable, 0);
    advance();

    // Idle drain
    mdu(1, 5'd5, 32'hDEADBEEF);
    step();
    mdu(0, 5'd0, 32'd0);
    settle();
    chk("drain_we", rf_rdWriteEnable, 1);
    chk("drain_addr", rf_rdAddr, 5);
    chk("drain_data", rf_rd, 32'hDEADBEEF);
    chk("drain_mask_set", pendingMask, 32'h20);
    advance();
    settle();
    chk("drain_mask_clr", pendingMask, 0);
    advance();

    // Priority and full FIFO
    wb(1, 5'd3, 32'd33);
    mdu(1, 5'd7, 32'd70);
    step();
    mdu(1, 5'd9, 32'd90);
    settle();
    chk("prio_count1", fifoCount, 1);
    chk("prio_addr", rf_rdAddr, 3);
    advance();
    mdu(1, 5'd11, 32'd110);
    settle();
    chk("full_count", fifoCount, 2);
    chk("full_ready", mdu_ready, 0);
    chk("full_mask", pendingMask, (32'd1 << 7) | (32'd1 << 9));
    advance();
    mdu(0, 5'd0, 32'd0);
    settle();
    chk("full_reject", fifoCount, 2);
    advance();

    // Starvation: three ungranted cycles so far, the loop bounds the rest
    ung = 3;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (pipelineStall === 1'b1) break;
      ung++;
      advance();
    end
    chk("starve_stall", pipelineStall, 1);
    chk("starve_cycles", ung, 8);
    chk("starve_addr", rf_rdAddr, 7);
    chk("starve_data", rf_rd, 70);
    advance();
    settle();
    chk("starve_release", pipelineStall, 0);
    chk("starve_wb_addr", rf_rdAddr, 3);
    chk("starve_wb_we", rf_rdWriteEnable, 1);
    advance();
    wb(0, 5'd0, 32'd0);
    step();

    // x0 filtering
    mdu(1, 5'd4, 32'd44);
    step();
    mdu(0, 5'd0, 32'd0);
    wb(1, 5'd0, 32'h1234);
    settle();
    chk("x0_wb_addr", rf_rdAddr, 4);
    chk("x0_wb_data", rf_rd, 44);
    chk("x0_wb_we", rf_rdWriteEnable, 1);
    advance();
    wb(0, 5'd0, 32'd0);
    mdu(1, 5'd0, 32'h55);
    step();
    mdu(0, 5'd0, 32'd0);
    settle();
    chk("x0_mdu_count", fifoCount, 0);
    chk("x0_mdu_we", rf_rdWriteEnable, 0);
    advance();

    // Reset mid-traffic
    wb(1, 5'd3, 32'd33);
    mdu(1, 5'd12, 32'd12);
    step();
    mdu(1, 5'd13, 32'd13);
    step();
    mdu(0, 5'd0, 32'd0);
    settle();
    chk("mid_count_pre", fifoCount, 2);
    advance();
    reset = 1'b0;
    step();
    reset = 1'b1;
    wb(0, 5'd0, 32'd0);
    settle();
    chk("mid_count", fifoCount, 0);
    chk("mid_ready", mdu_ready, 1);
    chk("mid_mask", pendingMask, 0);
    chk("mid_stall", pipelineStall, 0);
    advance();

    // Wrap-around with back-to-back push and pop
    for (int k = 1; k <= 7; k++) begin
      if (k <= 6) mdu(1, 5'(10 + k), 32'(k));
      else        mdu(0, 5'd0, 32'd0);
      settle();
      if (k >= 2) begin
        chk("wrap_we", rf_rdWriteEnable, 1);
        chk("wrap_data", rf_rd, 32'(k - 1));
      end
      chk("wrap_count_le2", (fifoCount <= 2), 1);
      advance();
    end

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) != 0);
      wb($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 7) == 0) wb_rdAddr = 5'd0;
      mdu($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 7) == 0) mdu_rdAddr = 5'd0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
